// File: rtl/rtc_secuenciador.sv
// rtc_secuenciador: command sequencer feeding the RTC bus-protocol block.
// Sweeps the nine time/date/chrono registers with reads and injects user write groups.
module rtc_secuenciador #(
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned TIMEOUT    = 512
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_hora,
   input  logic        req_fecha,
   input  logic        req_crono,
   input  logic [23:0] wr_hora,
   input  logic [23:0] wr_fecha,
   input  logic [23:0] wr_crono,
   input  logic        tx_done,
   output logic [7:0]  address,
   output logic [7:0]  DATA_WRITE,
   output logic        IndicadorMaquina,
   output logic        tx_start,
   output logic        camb_hora,
   output logic        camb_fecha,
   output logic        camb_crono,
   output logic [3:0]  reg_index,
   output logic        busy,
   output logic        err_timeout
);
   localparam int unsigned CNT_MAX   = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam int unsigned SLOT_LAST = 8;
   localparam logic [7:0]  CMD_CODE  = 8'hF1;

   typedef enum logic [1:0] {S_GAP, S_ISSUE, S_WAIT} state_e;
   typedef enum logic [1:0] {G_NONE, G_HORA, G_FECHA, G_CRONO} group_e;

   state_e             state_q, state_d;
   group_e             group_q, group_d, sel_grp;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         step_q, step_d, sel_step, last_step;
   logic [3:0]         reg_index_q, reg_index_d;
   logic               pend_hora_q, pend_hora_d, pend_fecha_q, pend_fecha_d;
   logic               pend_crono_q, pend_crono_d;
   logic [23:0]        hora_q, hora_d, fecha_q, fecha_d, crono_q, crono_d;
   logic [23:0]        grp_src;
   logic [7:0]         grp_base, grp_byte;
   logic [7:0]         address_q, address_d, data_wr_q, data_wr_d;
   logic               ind_q, ind_d, tx_start_q, tx_start_d, busy_q, busy_d;
   logic               err_timeout_q, err_timeout_d;
   logic               camb_hora_q, camb_hora_d, camb_fecha_q, camb_fecha_d;
   logic               camb_crono_q, camb_crono_d;
   logic               gap_end, wait_tmo;

   function automatic logic [7:0] sweep_addr(input logic [3:0] idx);
      case (idx)
         4'd0:    return 8'h21;
         4'd1:    return 8'h22;
         4'd2:    return 8'h23;
         4'd3:    return 8'h24;
         4'd4:    return 8'h25;
         4'd5:    return 8'h26;
         4'd6:    return 8'h41;
         4'd7:    return 8'h42;
         4'd8:    return 8'h43;
         default: return 8'h21;
      endcase
   endfunction

   assign gap_end  = (cnt_q == CNT_W'(GAP_CYCLES - 1));
   assign wait_tmo = (cnt_q == CNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_GAP;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_GAP:   if (gap_end) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (tx_done || wait_tmo) state_d = S_GAP;
         default: state_d = S_GAP;
      endcase
   end

   // Datapath and output logic
   always_comb begin
      cnt_d         = cnt_q;
      group_d       = group_q;
      step_d        = step_q;
      reg_index_d   = reg_index_q;
      pend_hora_d   = pend_hora_q;
      pend_fecha_d  = pend_fecha_q;
      pend_crono_d  = pend_crono_q;
      hora_d        = hora_q;
      fecha_d       = fecha_q;
      crono_d       = crono_q;
      address_d     = address_q;
      data_wr_d     = data_wr_q;
      ind_d         = ind_q;
      busy_d        = busy_q;
      camb_hora_d   = camb_hora_q;
      camb_fecha_d  = camb_fecha_q;
      camb_crono_d  = camb_crono_q;
      tx_start_d    = 1'b0;
      err_timeout_d = 1'b0;
      sel_grp       = group_q;
      sel_step      = step_q;
      grp_base      = 8'h41;
      grp_src       = crono_q;
      grp_byte      = 8'h00;
      last_step     = (group_q == G_CRONO) ? 2'd2 : 2'd3;

      case (state_q)
         S_GAP: begin
            cnt_d = gap_end ? '0 : cnt_q + CNT_W'(1);
         end
         S_ISSUE: begin
            // An unfinished group always wins; otherwise pick pending requests by priority
            if (group_q == G_NONE) begin
               sel_step = 2'd0;
               if (pend_hora_q) begin
                  sel_grp     = G_HORA;
                  pend_hora_d = 1'b0;
               end else if (pend_fecha_q) begin
                  sel_grp      = G_FECHA;
                  pend_fecha_d = 1'b0;
               end else if (pend_crono_q) begin
                  sel_grp      = G_CRONO;
                  pend_crono_d = 1'b0;
               end
            end
            case (sel_grp)
               G_HORA:  begin grp_base = 8'h21; grp_src = hora_q;  end
               G_FECHA: begin grp_base = 8'h24; grp_src = fecha_q; end
               default: begin grp_base = 8'h41; grp_src = crono_q; end
            endcase
            case (sel_step)
               2'd0:    grp_byte = grp_src[7:0];
               2'd1:    grp_byte = grp_src[15:8];
               default: grp_byte = grp_src[23:16];
            endcase
            if (sel_grp != G_NONE) begin
               address_d    = (sel_step == 2'd3) ? CMD_CODE : grp_base + 8'(sel_step);
               data_wr_d    = (sel_step == 2'd3) ? CMD_CODE : grp_byte;
               ind_d        = 1'b0;
               group_d      = sel_grp;
               step_d       = sel_step;
               camb_hora_d  = (sel_grp == G_HORA);
               camb_fecha_d = (sel_grp == G_FECHA);
               camb_crono_d = (sel_grp == G_CRONO);
            end else begin
               address_d = sweep_addr(reg_index_q);
               data_wr_d = 8'h00;
               ind_d     = 1'b1;
            end
            tx_start_d = 1'b1;
            busy_d     = 1'b1;
            cnt_d      = '0;
         end
         S_WAIT: begin
            if (tx_done || wait_tmo) begin
               err_timeout_d = !tx_done;
               busy_d        = 1'b0;
               cnt_d         = '0;
               // Aborted transactions still advance; nothing is retried
               if (!ind_q) begin
                  if (step_q == last_step) begin
                     group_d      = G_NONE;
                     step_d       = 2'd0;
                     camb_hora_d  = 1'b0;
                     camb_fecha_d = 1'b0;
                     camb_crono_d = 1'b0;
                  end else begin
                     step_d = step_q + 2'd1;
                  end
               end else begin
                  reg_index_d = (reg_index_q == 4'(SLOT_LAST)) ? 4'd0 : reg_index_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: cnt_d = '0;
      endcase

      // Requests are captured in every state; a repeat just refreshes the data
      if (req_hora) begin
         pend_hora_d = 1'b1;
         hora_d      = wr_hora;
      end
      if (req_fecha) begin
         pend_fecha_d = 1'b1;
         fecha_d      = wr_fecha;
      end
      if (req_crono) begin
         pend_crono_d = 1'b1;
         crono_d      = wr_crono;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q         <= '0;
         group_q       <= G_NONE;
         step_q        <= 2'd0;
         reg_index_q   <= 4'd0;
         pend_hora_q   <= 1'b0;
         pend_fecha_q  <= 1'b0;
         pend_crono_q  <= 1'b0;
         hora_q        <= 24'h0;
         fecha_q       <= 24'h0;
         crono_q       <= 24'h0;
         address_q     <= 8'h00;
         data_wr_q     <= 8'h00;
         ind_q         <= 1'b1;
         tx_start_q    <= 1'b0;
         busy_q        <= 1'b0;
         err_timeout_q <= 1'b0;
         camb_hora_q   <= 1'b0;
         camb_fecha_q  <= 1'b0;
         camb_crono_q  <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         group_q       <= group_d;
         step_q        <= step_d;
         reg_index_q   <= reg_index_d;
         pend_hora_q   <= pend_hora_d;
         pend_fecha_q  <= pend_fecha_d;
         pend_crono_q  <= pend_crono_d;
         hora_q        <= hora_d;
         fecha_q       <= fecha_d;
         crono_q       <= crono_d;
         address_q     <= address_d;
         data_wr_q     <= data_wr_d;
         ind_q         <= ind_d;
         tx_start_q    <= tx_start_d;
         busy_q        <= busy_d;
         err_timeout_q <= err_timeout_d;
         camb_hora_q   <= camb_hora_d;
         camb_fecha_q  <= camb_fecha_d;
         camb_crono_q  <= camb_crono_d;
      end
   end

   assign address          = address_q;
   assign DATA_WRITE       = data_wr_q;
   assign IndicadorMaquina = ind_q;
   assign tx_start         = tx_start_q;
   assign busy             = busy_q;
   assign err_timeout      = err_timeout_q;
   assign camb_hora        = camb_hora_q;
   assign camb_fecha       = camb_fecha_q;
   assign camb_crono       = camb_crono_q;
   assign reg_index        = reg_index_q;

endmodule
